// File: rtl/verdict_gate.sv
// rtl/verdict_gate.sv - holds each packet until its parser verdict pops, then forwards or drops it.
// Keeps passed-packet, dropped-packet and dropped-byte counters.
module verdict_gate #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int RESULT_WIDTH         = 105
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [RESULT_WIDTH-1:0]           result_dout,
  input  logic                              result_empty,
  output logic                              result_rd_en,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              cnt_clear,
  output logic [31:0]                       pass_pkts,
  output logic [31:0]                       drop_pkts,
  output logic [31:0]                       drop_bytes
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pass_pkts_q, pass_pkts_d;
  logic [31:0] drop_pkts_q, drop_pkts_d;
  logic [31:0] drop_bytes_q, drop_bytes_d;
  logic [31:0] strb_bytes;
  logic        unused_tuple;

  // Only the send bit matters here; the flow tuple is for other consumers.
  assign unused_tuple = ^result_dout[RESULT_WIDTH-2:0];

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tstrb = s_axis_tstrb;
  assign m_axis_tuser = s_axis_tuser;
  assign m_axis_tlast = s_axis_tlast;

  assign pass_pkts  = pass_pkts_q;
  assign drop_pkts  = drop_pkts_q;
  assign drop_bytes = drop_bytes_q;

  always_comb begin
    strb_bytes = '0;
    for (int i = 0; i < C_S_AXIS_DATA_WIDTH/8; i++) begin
      strb_bytes = strb_bytes + 32'(s_axis_tstrb[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    pass_pkts_d   = pass_pkts_q;
    drop_pkts_d   = drop_pkts_q;
    drop_bytes_d  = drop_bytes_q;
    result_rd_en  = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;

    case (state_q)
      IDLE: begin
        if (!result_empty) begin
          result_rd_en = 1'b1;
          state_d      = result_dout[RESULT_WIDTH-1] ? PASS : DROP;
        end
      end
      PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pass_pkts_d = pass_pkts_q + 32'd1;
          state_d     = IDLE;
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          drop_bytes_d = drop_bytes_q + strb_bytes;
          if (s_axis_tlast) begin
            drop_pkts_d = drop_pkts_q + 32'd1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over any increment landing in the same cycle.
    if (cnt_clear) begin
      pass_pkts_d  = '0;
      drop_pkts_d  = '0;
      drop_bytes_d = '0;
    end

    if (!axi_aresetn) begin
      result_rd_en  = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q      <= IDLE;
      pass_pkts_q  <= '0;
      drop_pkts_q  <= '0;
      drop_bytes_q <= '0;
    end else begin
      state_q      <= state_d;
      pass_pkts_q  <= pass_pkts_d;
      drop_pkts_q  <= drop_pkts_d;
      drop_bytes_q <= drop_bytes_d;
    end
  end

endmodule

// File: tb/tb_verdict_gate.sv
// tb/tb_verdict_gate.sv - directed vector table plus multi-cycle sequences for verdict_gate.
module tb_verdict_gate;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int RW = 105;

  logic            clk;
  logic            resetn;
  logic [RW-1:0]   result_dout;
  logic            result_empty;
  logic            result_rd_en;
  logic [DW-1:0]   s_tdata;
  logic [DW/8-1:0] s_tstrb;
  logic [UW-1:0]   s_tuser;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [DW-1:0]   m_tdata;
  logic [DW/8-1:0] m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic            cnt_clear;
  logic [31:0]     pass_pkts;
  logic [31:0]     drop_pkts;
  logic [31:0]     drop_bytes;

  int checks = 0;
  int errors = 0;

  verdict_gate dut (
    .axi_aclk      (clk),
    .axi_aresetn   (resetn),
    .result_dout   (result_dout),
    .result_empty  (result_empty),
    .result_rd_en  (result_rd_en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .cnt_clear     (cnt_clear),
    .pass_pkts     (pass_pkts),
    .drop_pkts     (drop_pkts),
    .drop_bytes    (drop_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        emp;
    logic        snd;
    logic        vld;
    logic        lst;
    logic [31:0] stb;
    logic [7:0]  tag;
    logic        mrdy;
    logic        clr;
    logic        rd;
    logic        srdy;
    logic        mvld;
    logic [31:0] pass;
    logic [31:0] dpk;
    logic [31:0] dby;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic emp, input logic snd, input logic vld, input logic lst,
                       input logic [31:0] stb, input logic [7:0] tag, input logic mrdy,
                       input logic clr);
    result_empty = emp;
    result_dout  = '0;
    result_dout[RW-1] = snd;
    result_dout[7:0]  = tag;
    s_tvalid  = vld;
    s_tlast   = lst;
    s_tstrb   = stb;
    s_tdata   = {32{tag}};
    s_tuser   = {16{tag}};
    m_tready  = mrdy;
    cnt_clear = clr;
  endtask

  function automatic vec_t mk(logic emp, logic snd, logic vld, logic lst, logic [31:0] stb,
                              logic [7:0] tag, logic mrdy, logic clr, logic rd, logic srdy,
                              logic mvld, logic [31:0] pass, logic [31:0] dpk, logic [31:0] dby);
    vec_t v;
    v.emp = emp; v.snd = snd; v.vld = vld; v.lst = lst; v.stb = stb; v.tag = tag;
    v.mrdy = mrdy; v.clr = clr; v.rd = rd; v.srdy = srdy; v.mvld = mvld;
    v.pass = pass; v.dpk = dpk; v.dby = dby;
    return v;
  endfunction

  initial begin
    int idx;
    logic rdy;

    // Expected counters are the values visible while the step's inputs are applied.
    vt[0]  = mk(0, 1, 1, 0, 32'hFFFFFFFF, 8'hA1, 1, 0,  1, 0, 0,  0, 0, 0);
    vt[1]  = mk(1, 0, 1, 0, 32'hFFFFFFFF, 8'hA1, 1, 0,  0, 1, 1,  0, 0, 0);
    vt[2]  = mk(1, 0, 1, 0, 32'hFFFFFFFF, 8'hA2, 1, 0,  0, 1, 1,  0, 0, 0);
    vt[3]  = mk(1, 0, 1, 1, 32'hFFFFFFFF, 8'hA3, 1, 0,  0, 1, 1,  0, 0, 0);
    vt[4]  = mk(0, 0, 1, 0, 32'hFFFFFFFF, 8'hB1, 1, 0,  1, 0, 0,  1, 0, 0);
    vt[5]  = mk(1, 0, 1, 0, 32'hFFFFFFFF, 8'hB1, 1, 0,  0, 1, 0,  1, 0, 0);
    vt[6]  = mk(1, 0, 1, 1, 32'h0000003F, 8'hB2, 1, 0,  0, 1, 0,  1, 0, 32);
    vt[7]  = mk(0, 1, 1, 1, 32'hFFFFFFFF, 8'hC1, 1, 1,  1, 0, 0,  1, 1, 38);
    vt[8]  = mk(0, 0, 1, 1, 32'hFFFFFFFF, 8'hC1, 1, 0,  0, 1, 1,  0, 0, 0);
    vt[9]  = mk(0, 0, 1, 1, 32'h0000000F, 8'hD1, 1, 0,  1, 0, 0,  1, 0, 0);
    vt[10] = mk(0, 1, 1, 1, 32'h0000000F, 8'hD1, 1, 0,  0, 1, 0,  1, 0, 0);
    vt[11] = mk(0, 1, 1, 1, 32'hFFFFFFFF, 8'hE1, 1, 0,  1, 0, 0,  1, 1, 4);
    vt[12] = mk(1, 0, 1, 1, 32'hFFFFFFFF, 8'hE1, 1, 1,  0, 1, 1,  1, 1, 4);
    vt[13] = mk(1, 0, 0, 0, 32'h00000000, 8'h00, 1, 0,  0, 0, 0,  0, 0, 0);

    resetn = 1'b0;
    drive(0, 1, 1, 1, 32'hFFFFFFFF, 8'h11, 1, 0);
    repeat (3) @(negedge clk);
    #2;
    chk("reset rd_en", result_rd_en, 0);
    chk("reset s_tready", s_tready, 0);
    chk("reset m_tvalid", m_tvalid, 0);
    chk("reset pass", pass_pkts, 0);
    chk("reset drop", drop_pkts, 0);
    chk("reset bytes", drop_bytes, 0);
    drive(1, 0, 0, 0, 32'h0, 8'h00, 1, 0);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i].emp, vt[i].snd, vt[i].vld, vt[i].lst, vt[i].stb, vt[i].tag, vt[i].mrdy, vt[i].clr);
      #2;
      chk($sformatf("vec%0d rd_en", i), result_rd_en, vt[i].rd);
      chk($sformatf("vec%0d s_tready", i), s_tready, vt[i].srdy);
      chk($sformatf("vec%0d m_tvalid", i), m_tvalid, vt[i].mvld);
      chk($sformatf("vec%0d pass", i), pass_pkts, vt[i].pass);
      chk($sformatf("vec%0d drop", i), drop_pkts, vt[i].dpk);
      chk($sformatf("vec%0d bytes", i), drop_bytes, vt[i].dby);
      if (vt[i].mvld) begin
        chk($sformatf("vec%0d m_tdata", i), m_tdata, {32{vt[i].tag}});
        chk($sformatf("vec%0d m_tlast", i), m_tlast, vt[i].lst);
      end
    end

    // Data waiting, verdict FIFO empty: nothing moves.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1, 0, 1, 1, 32'hFFFFFFFF, 8'h51, 1, 0);
      #2;
      chk($sformatf("stall%0d s_tready", c), s_tready, 0);
      chk($sformatf("stall%0d m_tvalid", c), m_tvalid, 0);
    end
    @(negedge clk);
    drive(0, 1, 1, 1, 32'hFFFFFFFF, 8'h51, 1, 0);
    #2;
    chk("stall pop", result_rd_en, 1);
    @(negedge clk);
    drive(1, 0, 1, 1, 32'hFFFFFFFF, 8'h51, 1, 0);
    #2;
    chk("stall fwd m_tvalid", m_tvalid, 1);
    chk("stall fwd m_tdata", m_tdata, {32{8'h51}});
    @(negedge clk);
    drive(1, 0, 0, 0, 32'h0, 8'h00, 1, 0);
    #2;
    chk("stall pass", pass_pkts, 1);
    chk("stall idle s_tready", s_tready, 0);

    // Backpressure: ready toggles 1,0,1,0 over a 4-beat packet.
    @(negedge clk);
    drive(0, 1, 1, 0, 32'hFFFFFFFF, 8'h70, 0, 0);
    #2;
    chk("bp pop", result_rd_en, 1);
    idx = 0;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      @(negedge clk);
      rdy = (k % 2 == 0);
      drive(1, 0, 1, idx == 3, 32'hFFFFFFFF, 8'h70 + 8'(idx), rdy, 0);
      #2;
      chk($sformatf("bp%0d s_tready", k), s_tready, rdy);
      chk($sformatf("bp%0d m_tvalid", k), m_tvalid, 1);
      if (rdy) begin
        chk($sformatf("bp beat%0d data", idx), m_tdata, {32{8'h70 + 8'(idx)}});
        chk($sformatf("bp beat%0d last", idx), m_tlast, idx == 3);
        idx++;
      end
    end
    chk("bp beats", idx, 4);
    @(negedge clk);
    drive(1, 0, 0, 0, 32'h0, 8'h00, 1, 0);
    #2;
    chk("bp pass", pass_pkts, 2);
    chk("bp idle s_tready", s_tready, 0);

    // Reset on beat 2 of a PASS packet.
    @(negedge clk);
    drive(0, 1, 1, 0, 32'hFFFFFFFF, 8'h61, 1, 0);
    #2;
    chk("rst pop", result_rd_en, 1);
    @(negedge clk);
    drive(1, 0, 1, 0, 32'hFFFFFFFF, 8'h61, 1, 0);
    #2;
    chk("rst beat1 s_tready", s_tready, 1);
    @(negedge clk);
    drive(1, 0, 1, 0, 32'hFFFFFFFF, 8'h62, 1, 0);
    resetn = 1'b0;
    #2;
    chk("rst during s_tready", s_tready, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 1, 1, 0, 32'hFFFFFFFF, 8'h63, 1, 0);
    #2;
    chk("rst after s_tready", s_tready, 0);
    chk("rst after m_tvalid", m_tvalid, 0);
    chk("rst after idle pop", result_rd_en, 1);
    chk("rst after pass", pass_pkts, 0);
    chk("rst after drop", drop_pkts, 0);
    chk("rst after bytes", drop_bytes, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
